// File: rtl/rv32i_types.sv
// Shared core types: completed-instruction payload, writeback bus, FU channel indices.
package rv32i_types;

  localparam int unsigned ROB_NUM_BITS = 4;

  typedef struct packed {
    logic                    valid;
    logic [ROB_NUM_BITS-1:0] rob_addr;
    logic [4:0]              rd_addr;
    logic [5:0]              rd_paddr;
    logic [31:0]             rd_data;
  } ooo_instr_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic [5:0]  rd_paddr;
    logic [31:0] rd_data;
  } wb_bus_t;

  // Functional-unit channel indices; lower index means higher static priority.
  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_MEM = 1;
  localparam int unsigned FU_BR  = 2;
  localparam int unsigned FU_MUL = 3;
  localparam int unsigned FU_DIV = 4;

  // Project a completed instruction onto the writeback bus fields.
  function automatic wb_bus_t to_wb(input ooo_instr_t instr);
    wb_bus_t wb;
    wb.valid    = instr.valid;
    wb.rd_addr  = instr.rd_addr;
    wb.rd_paddr = instr.rd_paddr;
    wb.rd_data  = instr.rd_data;
    return wb;
  endfunction

endpackage

// File: rtl/cdb_chan_fifo.sv
// Per-channel circular FIFO decoupling one functional unit from the CDB arbiter.
// Ports: clk/rst (sync, active-high), i_flush empties the FIFO, i_push/i_din write,
// i_pop retires the head, o_head is the current head entry, o_count the occupancy.
module cdb_chan_fifo
  import rv32i_types::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  ooo_instr_t                       i_din,
  output ooo_instr_t                       o_head,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  ooo_instr_t       r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Pointer increment wrapping at BUF_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is not reset; only entries below the count are ever observed.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_tail] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= next_ptr(r_tail);
      if (i_pop)  r_head <= next_ptr(r_head);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && i_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback / common-data-bus arbiter: buffers completed instructions per FU channel
// and broadcasts up to NUM_CDB FIFO heads per cycle (round-robin or fixed priority).
// Ports: clk/rst (sync, active-high), flush drops buffered and incoming results,
// fu_in/fu_ready per-channel handshake, cdb_out/cdb_instr/rob_addr/push_status the
// registered broadcast, buf_count per-channel occupancy.
// Legal configurations: 1 <= NUM_CDB <= NUM_FU, BUF_DEPTH >= 1.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_FU    = 5,
  parameter int unsigned NUM_CDB   = 1,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned RR_MODE   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  ooo_instr_t                      fu_in       [NUM_FU],
  output logic [NUM_FU-1:0]               fu_ready,
  output wb_bus_t                         cdb_out     [NUM_CDB],
  output ooo_instr_t                      cdb_instr   [NUM_CDB],
  output logic [NUM_CDB-1:0]              push_status,
  output logic [ROB_NUM_BITS-1:0]         rob_addr    [NUM_CDB],
  output logic [$clog2(BUF_DEPTH+1)-1:0]  buf_count   [NUM_FU]
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [CNT_W-1:0]  w_count    [NUM_FU];
  ooo_instr_t        w_head     [NUM_FU];
  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_pop;
  logic [NUM_FU-1:0] w_mask;
  logic [IDX_W-1:0]  w_start;
  logic [IDX_W-1:0]  w_last_idx;
  logic              w_any;
  logic              w_found;
  logic [IDX_W-1:0]  w_idx;
  logic [NUM_CDB-1:0] w_port_vld;
  logic [IDX_W-1:0]  w_port_idx [NUM_CDB];
  ooo_instr_t        w_sel      [NUM_CDB];

  logic [IDX_W-1:0]  r_rr_ptr;
  wb_bus_t           r_cdb_out   [NUM_CDB];
  ooo_instr_t        r_cdb_instr [NUM_CDB];
  logic [ROB_NUM_BITS-1:0] r_rob_addr [NUM_CDB];

  // Channel index visited at scan step k, starting from 'start'.
  function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] start,
                                                input int unsigned k);
    return IDX_W'((32'(start) + k) % NUM_FU);
  endfunction

  // Per-channel FIFOs; ready looks only at the registered count (no pop bypass).
  for (genvar i = 0; i < NUM_FU; i++) begin : g_chan
    assign fu_ready[i]  = (w_count[i] < CNT_W'(BUF_DEPTH));
    assign w_push[i]    = fu_in[i].valid && fu_ready[i] && !flush;
    assign w_req[i]     = (w_count[i] != '0);
    assign buf_count[i] = w_count[i];

    cdb_chan_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push[i]),
      .i_pop   (w_pop[i]),
      .i_din   (fu_in[i]),
      .o_head  (w_head[i]),
      .o_count (w_count[i])
    );
  end

  assign w_start = (RR_MODE != 0) ? r_rr_ptr : '0;

  // Each port takes the first still-unmasked head in scan order, then masks it off.
  always_comb begin
    w_mask     = w_req;
    w_pop      = '0;
    w_last_idx = '0;
    w_any      = 1'b0;
    w_found    = 1'b0;
    w_idx      = '0;
    w_port_vld = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      w_port_idx[p] = '0;
      w_found       = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
        w_idx = scan_idx(w_start, k);
        if (!w_found && w_mask[w_idx]) begin
          w_found       = 1'b1;
          w_port_vld[p] = 1'b1;
          w_port_idx[p] = w_idx;
          w_mask[w_idx] = 1'b0;
          w_pop[w_idx]  = 1'b1;
          w_last_idx    = w_idx;
          w_any         = 1'b1;
        end
      end
      w_sel[p] = w_head[w_port_idx[p]];
    end
  end

  // Rotate past the last granted channel; a flushed cycle's grant does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (!flush && w_any) begin
      r_rr_ptr <= (w_last_idx == IDX_W'(NUM_FU - 1)) ? '0 : w_last_idx + IDX_W'(1);
    end
  end

  // Broadcast registers; idle or flushed ports carry an all-zero payload.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_CDB; p++) begin
      if (rst || flush || !w_port_vld[p]) begin
        r_cdb_out[p]   <= '0;
        r_cdb_instr[p] <= '0;
        r_rob_addr[p]  <= '0;
      end else begin
        r_cdb_out[p]   <= to_wb(w_sel[p]);
        r_cdb_instr[p] <= w_sel[p];
        r_rob_addr[p]  <= w_sel[p].rob_addr;
      end
    end
  end

  assign cdb_out   = r_cdb_out;
  assign cdb_instr = r_cdb_instr;
  assign rob_addr  = r_rob_addr;

  for (genvar p = 0; p < NUM_CDB; p++) begin : g_port
    assign push_status[p] = r_cdb_out[p].valid;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: default RR single-port instance (a), fixed-priority
// instance (b) and dual-port round-robin instance (c).
module tb_cdb_arbiter;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_flush = 1'b0;

  always #5 clk = ~clk;

  ooo_instr_t a_in [5];
  logic [4:0] a_rdy;
  wb_bus_t    a_out [1];
  ooo_instr_t a_ins [1];
  logic [0:0] a_ps;
  logic [ROB_NUM_BITS-1:0] a_rob [1];
  logic [1:0] a_cnt [5];

  ooo_instr_t b_in [5];
  logic [4:0] b_rdy;
  wb_bus_t    b_out [1];
  ooo_instr_t b_ins [1];
  logic [0:0] b_ps;
  logic [ROB_NUM_BITS-1:0] b_rob [1];
  logic [1:0] b_cnt [5];

  ooo_instr_t c_in [5];
  logic [4:0] c_rdy;
  wb_bus_t    c_out [2];
  ooo_instr_t c_ins [2];
  logic [1:0] c_ps;
  logic [ROB_NUM_BITS-1:0] c_rob [2];
  logic [1:0] c_cnt [5];

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_FU(5), .NUM_CDB(1), .BUF_DEPTH(2), .RR_MODE(1)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .fu_in(a_in), .fu_ready(a_rdy),
    .cdb_out(a_out), .cdb_instr(a_ins), .push_status(a_ps), .rob_addr(a_rob),
    .buf_count(a_cnt));

  cdb_arbiter #(.NUM_FU(5), .NUM_CDB(1), .BUF_DEPTH(2), .RR_MODE(0)) u_b (
    .clk(clk), .rst(rst), .flush(1'b0), .fu_in(b_in), .fu_ready(b_rdy),
    .cdb_out(b_out), .cdb_instr(b_ins), .push_status(b_ps), .rob_addr(b_rob),
    .buf_count(b_cnt));

  cdb_arbiter #(.NUM_FU(5), .NUM_CDB(2), .BUF_DEPTH(2), .RR_MODE(1)) u_c (
    .clk(clk), .rst(rst), .flush(1'b0), .fu_in(c_in), .fu_ready(c_rdy),
    .cdb_out(c_out), .cdb_instr(c_ins), .push_status(c_ps), .rob_addr(c_rob),
    .buf_count(c_cnt));

  function automatic ooo_instr_t mk(input logic [3:0] rob, input logic [31:0] data);
    ooo_instr_t t;
    t.valid    = 1'b1;
    t.rob_addr = rob;
    t.rd_addr  = data[4:0];
    t.rd_paddr = data[10:5];
    t.rd_data  = data;
    return t;
  endfunction

  function automatic wb_bus_t wb_of(input ooo_instr_t t);
    wb_bus_t w;
    w.valid    = t.valid;
    w.rd_addr  = t.rd_addr;
    w.rd_paddr = t.rd_paddr;
    w.rd_data  = t.rd_data;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      c_in[i] = '0;
    end

    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_a_out",   64'(a_out[0]), 64'(0));
    chk("rst_a_ins",   64'(a_ins[0]), 64'(0));
    chk("rst_a_ps",    64'(a_ps), 64'(0));
    chk("rst_a_rob",   64'(a_rob[0]), 64'(0));
    chk("rst_a_rdy",   64'(a_rdy), 64'(5'b11111));
    chk("rst_a_cnt",   64'({a_cnt[0], a_cnt[1], a_cnt[2], a_cnt[3], a_cnt[4]}), 64'(0));
    chk("rst_b_rdy",   64'(b_rdy), 64'(5'b11111));
    chk("rst_c_rdy",   64'(c_rdy), 64'(5'b11111));
    chk("rst_c_ps",    64'(c_ps), 64'(0));
    rst = 1'b0;

    // Single-path latency on the ALU channel.
    a_in[FU_ALU] = mk(4'd3, 32'hDEADBEEF);
    tick();
    a_in[FU_ALU] = '0;
    chk("lat_e1_cnt",   64'(a_cnt[0]), 64'(1));
    chk("lat_e1_valid", 64'(a_out[0].valid), 64'(0));
    tick();
    chk("lat_e2_out",  64'(a_out[0]), 64'(wb_of(mk(4'd3, 32'hDEADBEEF))));
    chk("lat_e2_ins",  64'(a_ins[0]), 64'(mk(4'd3, 32'hDEADBEEF)));
    chk("lat_e2_ps",   64'(a_ps), 64'(1));
    chk("lat_e2_rob",  64'(a_rob[0]), 64'(3));
    chk("lat_e2_cnt",  64'(a_cnt[0]), 64'(0));
    tick();
    chk("lat_e3_out",  64'(a_out[0]), 64'(0));
    chk("lat_e3_ps",   64'(a_ps), 64'(0));

    // Round-robin rotation: re-reset so the pointer starts at channel 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 2; e++) begin
      for (int ch = 0; ch < 5; ch++)
        a_in[ch] = mk(4'(ch * 2 + e), 32'(32'h100 * ch + e));
      tick();
    end
    for (int ch = 0; ch < 5; ch++) a_in[ch] = '0;
    for (int g = 0; g < 10; g++) begin
      chk($sformatf("rr_grant%0d", g), 64'(a_out[0]),
          64'(wb_of(mk(4'((g % 5) * 2 + g / 5), 32'(32'h100 * (g % 5) + g / 5)))));
      tick();
    end
    chk("rr_idle_valid", 64'(a_out[0].valid), 64'(0));
    chk("rr_idle_cnt",   64'({a_cnt[0], a_cnt[1], a_cnt[2], a_cnt[3], a_cnt[4]}), 64'(0));

    // Flush: channels 1 and 3 loaded, then new entries injected under flush.
    a_in[1] = mk(4'd1, 32'hF1);
    a_in[3] = mk(4'd3, 32'hF3);
    tick();
    a_in[1] = mk(4'd9, 32'hF11);
    a_in[3] = mk(4'd11, 32'hF13);
    tick();
    chk("fl_pre_out",  64'(a_out[0]), 64'(wb_of(mk(4'd1, 32'hF1))));
    chk("fl_pre_cnt3", 64'(a_cnt[3]), 64'(2));
    chk("fl_pre_cnt1", 64'(a_cnt[1]), 64'(1));
    chk("fl_pre_rdy",  64'(a_rdy), 64'(5'b10111));
    a_flush = 1'b1;
    a_in[1] = mk(4'd12, 32'hBAD1);
    a_in[3] = mk(4'd13, 32'hBAD3);
    tick();
    a_flush = 1'b0;
    a_in[1] = '0;
    a_in[3] = '0;
    chk("fl_out",  64'(a_out[0]), 64'(0));
    chk("fl_ps",   64'(a_ps), 64'(0));
    chk("fl_cnt",  64'({a_cnt[0], a_cnt[1], a_cnt[2], a_cnt[3], a_cnt[4]}), 64'(0));
    chk("fl_rdy",  64'(a_rdy), 64'(5'b11111));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_quiet%0d", k), 64'(a_out[0]), 64'(0));
    end

    // Fixed priority: channel 0 starves channel 4 while it stays valid.
    b_in[0] = mk(4'd0, 32'hA0);
    b_in[4] = mk(4'd4, 32'hA4);
    tick();
    tick();
    chk("fp_e2_out",  64'(b_out[0]), 64'(wb_of(mk(4'd0, 32'hA0))));
    chk("fp_e2_cnt4", 64'(b_cnt[4]), 64'(2));
    chk("fp_e2_rdy4", 64'(b_rdy[4]), 64'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fp_hold_out%0d", k), 64'(b_out[0]), 64'(wb_of(mk(4'd0, 32'hA0))));
      chk($sformatf("fp_hold_cnt%0d", k), 64'({b_cnt[0], b_cnt[4], b_rdy}),
          64'({2'd1, 2'd2, 5'b01111}));
    end
    chk("fp_ps",  64'(b_ps), 64'(1));
    chk("fp_rob", 64'(b_rob[0]), 64'(0));
    b_in[0] = '0;
    tick();
    chk("fp_drain0", 64'(b_out[0]), 64'(wb_of(mk(4'd0, 32'hA0))));
    tick();
    chk("fp_ch4_ins", 64'(b_ins[0]), 64'(mk(4'd4, 32'hA4)));
    b_in[4] = '0;

    // Dual port: set rr_ptr to 2 by granting channels 0 and 1 together.
    c_in[0] = mk(4'd0, 32'hC00);
    c_in[1] = mk(4'd1, 32'hC10);
    c_in[2] = mk(4'd2, 32'hC20);
    c_in[3] = mk(4'd3, 32'hC30);
    tick();
    c_in[0] = '0;
    c_in[2] = '0;
    c_in[3] = '0;
    c_in[1] = mk(4'd5, 32'hC11);
    tick();
    c_in[1] = '0;
    chk("dp_e2_p0", 64'(c_out[0]), 64'(wb_of(mk(4'd0, 32'hC00))));
    chk("dp_e2_p1", 64'(c_out[1]), 64'(wb_of(mk(4'd1, 32'hC10))));
    tick();
    chk("dp_e3_p0",   64'(c_out[0]), 64'(wb_of(mk(4'd2, 32'hC20))));
    chk("dp_e3_p1",   64'(c_out[1]), 64'(wb_of(mk(4'd3, 32'hC30))));
    chk("dp_e3_rob1", 64'(c_rob[1]), 64'(3));
    c_in[0] = mk(4'd6, 32'hC01);
    c_in[3] = mk(4'd7, 32'hC31);
    tick();
    c_in[0] = '0;
    c_in[3] = '0;
    chk("dp_e4_p0",  64'(c_ins[0]), 64'(mk(4'd5, 32'hC11)));
    chk("dp_e4_p1",  64'(c_out[1]), 64'(0));
    chk("dp_e4_ps",  64'(c_ps), 64'(2'b01));
    tick();
    chk("dp_e5_p0",  64'(c_out[0]), 64'(wb_of(mk(4'd7, 32'hC31))));
    chk("dp_e5_p1",  64'(c_ins[1]), 64'(mk(4'd6, 32'hC01)));
    tick();
    chk("dp_e6_ps",  64'(c_ps), 64'(0));
    chk("dp_e6_cnt", 64'({c_cnt[0], c_cnt[1], c_cnt[2], c_cnt[3], c_cnt[4]}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
